// File: rtl/lsu_mem_master_pkg.sv
// Shared types, size codes and size helpers for the load/store unit.
package lsu_mem_master_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_BEAT0 = 2'd1,
        LSU_BEAT1 = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] FUNCT3_BYTE          = 3'b000;
    localparam logic [2:0] FUNCT3_HALF          = 3'b001;
    localparam logic [2:0] FUNCT3_WORD          = 3'b010;
    localparam logic [2:0] FUNCT3_BYTE_UNSIGNED = 3'b100;
    localparam logic [2:0] FUNCT3_HALF_UNSIGNED = 3'b101;

    // Stores only come in signed sizes; loads also have the unsigned variants.
    function automatic logic size_legal(input logic write, input logic [2:0] size);
        logic ok;
        ok = (size == FUNCT3_BYTE) || (size == FUNCT3_HALF) || (size == FUNCT3_WORD);
        if (!write) begin
            ok = ok || (size == FUNCT3_BYTE_UNSIGNED) || (size == FUNCT3_HALF_UNSIGNED);
        end
        return ok;
    endfunction

    // Byte-lane mask of an access before it is shifted to its offset.
    function automatic logic [LANES-1:0] size_mask(input logic [2:0] size);
        logic [LANES-1:0] mask;
        case (size[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

    // Only word accesses off a word boundary and halves at offset 3 cross into the next word.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        return ((size == FUNCT3_WORD) && (off != 2'b00)) ||
               ((size[1:0] == 2'b01) && (off == 2'b11));
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Word-wide data-memory bus with req/ack handshake and byte strobes.
interface lsu_mem_master_if #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_LEN  = 32
);
    logic                 memReq;
    logic                 memWe;
    logic [ADDR_SIZE-1:0] memAddr;
    logic [3:0]           memWStrb;
    logic [WORD_LEN-1:0]  memWData;
    logic                 memAck;
    logic [WORD_LEN-1:0]  memRData;

    modport master (
        output memReq, memWe, memAddr, memWStrb, memWData,
        input  memAck, memRData
    );

    modport slave (
        input  memReq, memWe, memAddr, memWStrb, memWData,
        output memAck, memRData
    );
endinterface

// File: rtl/lsu_mem_master_lane_align.sv
// Lane steering: store strobes/data per beat and extraction/extension of load data.
module lsu_lane_align
    import lsu_mem_master_pkg::*;
#(
    parameter int WORD_LEN = 32
) (
    input  logic [2:0]          size,
    input  logic [1:0]          offset,
    input  logic                beat,
    input  logic [WORD_LEN-1:0] store_data,
    input  logic [WORD_LEN-1:0] lo_word,
    input  logic [WORD_LEN-1:0] hi_word,
    output logic [3:0]          strb,
    output logic [WORD_LEN-1:0] wdata,
    output logic [WORD_LEN-1:0] load_data
);

    logic [7:0]            strb_wide;
    logic [2*WORD_LEN-1:0] data_wide;
    logic [WORD_LEN-1:0]   load_word;

    // Shift across a two-word window; beat 0 takes the low word, beat 1 the spill-over.
    always_comb begin
        strb_wide = {4'b0000, size_mask(size)} << offset;
        data_wide = {{WORD_LEN{1'b0}}, store_data} << {offset, 3'b000};
        strb      = beat ? strb_wide[7:4] : strb_wide[3:0];
        wdata     = beat ? data_wide[2*WORD_LEN-1:WORD_LEN] : data_wide[WORD_LEN-1:0];
        load_word = WORD_LEN'({hi_word, lo_word} >> {offset, 3'b000});
        case (size)
            FUNCT3_BYTE:          load_data = {{(WORD_LEN-8){load_word[7]}}, load_word[7:0]};
            FUNCT3_BYTE_UNSIGNED: load_data = {{(WORD_LEN-8){1'b0}}, load_word[7:0]};
            FUNCT3_HALF:          load_data = {{(WORD_LEN-16){load_word[15]}}, load_word[15:0]};
            FUNCT3_HALF_UNSIGNED: load_data = {{(WORD_LEN-16){1'b0}}, load_word[15:0]};
            default:              load_data = load_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit master: one MEM-stage access at a time, split into one or two bus beats.
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter int ADDR_SIZE        = 32,
    parameter int WORD_LEN         = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reqValid,
    input  logic                 reqWrite,
    input  logic [2:0]           unitSize,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [WORD_LEN-1:0]  writeData,
    input  logic [ADDR_SIZE-1:0] pc_MEM,
    output logic                 busy,
    output logic                 respValid,
    output logic [WORD_LEN-1:0]  readData,
    output logic                 fault,
    lsu_mem_master_if.master     mem
);

    lsu_state_t          state;
    logic                write_q;
    logic                split_q;
    logic [2:0]          size_q;
    logic [1:0]          off_q;
    logic [WORD_LEN-1:0] wdata_q;
    logic [WORD_LEN-1:0] beat0_word;

    logic [2:0]          align_size;
    logic [1:0]          align_off;
    logic                align_beat;
    logic [WORD_LEN-1:0] align_store;
    logic [WORD_LEN-1:0] align_lo;
    logic [WORD_LEN-1:0] align_hi;
    logic [3:0]          align_strb;
    logic [WORD_LEN-1:0] align_wdata;
    logic [WORD_LEN-1:0] align_load;

    logic                 accept_legal;
    logic                 accept_mis;
    logic [ADDR_SIZE-1:0] word_addr;
    logic                 unused_pc;

    assign accept_legal = size_legal(reqWrite, unitSize);
    assign accept_mis   = is_misaligned(unitSize, addr[1:0]);
    assign word_addr    = {addr[ADDR_SIZE-1:2], 2'b00};
    assign unused_pc    = ^pc_MEM;

    // Stall the accepting cycle combinationally, then for as long as a bus beat is outstanding.
    assign busy = (state == LSU_IDLE) ? (reqValid && rst_n) : (state != LSU_RESP);

    // Feed the aligner live inputs while accepting, the latched request afterwards.
    always_comb begin
        align_size  = size_q;
        align_off   = off_q;
        align_store = wdata_q;
        align_beat  = 1'b1;
        align_lo    = mem.memRData;
        align_hi    = '0;
        if (state == LSU_IDLE) begin
            align_size  = unitSize;
            align_off   = addr[1:0];
            align_store = writeData;
            align_beat  = 1'b0;
        end
        if (state == LSU_BEAT1) begin
            align_lo = beat0_word;
            align_hi = mem.memRData;
        end
    end

    lsu_lane_align #(.WORD_LEN(WORD_LEN)) u_align (
        .size       (align_size),
        .offset     (align_off),
        .beat       (align_beat),
        .store_data (align_store),
        .lo_word    (align_lo),
        .hi_word    (align_hi),
        .strb       (align_strb),
        .wdata      (align_wdata),
        .load_data  (align_load)
    );

    // Access FSM with registered bus and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LSU_IDLE;
            mem.memReq   <= 1'b0;
            mem.memWe    <= 1'b0;
            mem.memAddr  <= '0;
            mem.memWStrb <= '0;
            mem.memWData <= '0;
            respValid    <= 1'b0;
            fault        <= 1'b0;
            readData     <= '0;
            write_q      <= 1'b0;
            split_q      <= 1'b0;
            size_q       <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            beat0_word   <= '0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (reqValid) begin
                        write_q <= reqWrite;
                        size_q  <= unitSize;
                        off_q   <= addr[1:0];
                        wdata_q <= writeData;
                        split_q <= accept_mis;
                        if (!accept_legal || (accept_mis && !ALLOW_MISALIGNED)) begin
                            state     <= LSU_RESP;
                            respValid <= 1'b1;
                            fault     <= 1'b1;
                        end else begin
                            state        <= LSU_BEAT0;
                            mem.memReq   <= 1'b1;
                            mem.memWe    <= reqWrite;
                            mem.memAddr  <= word_addr;
                            mem.memWStrb <= reqWrite ? align_strb : 4'b0000;
                            mem.memWData <= reqWrite ? align_wdata : '0;
                        end
                    end
                end
                LSU_BEAT0: begin
                    if (mem.memAck) begin
                        if (split_q) begin
                            state        <= LSU_BEAT1;
                            beat0_word   <= mem.memRData;
                            mem.memAddr  <= mem.memAddr + ADDR_SIZE'(4);
                            mem.memWStrb <= write_q ? align_strb : 4'b0000;
                            mem.memWData <= write_q ? align_wdata : '0;
                        end else begin
                            state        <= LSU_RESP;
                            mem.memReq   <= 1'b0;
                            mem.memWe    <= 1'b0;
                            mem.memWStrb <= '0;
                            mem.memWData <= '0;
                            respValid    <= 1'b1;
                            if (!write_q) begin
                                readData <= align_load;
                            end
                        end
                    end
                end
                LSU_BEAT1: begin
                    if (mem.memAck) begin
                        state        <= LSU_RESP;
                        mem.memReq   <= 1'b0;
                        mem.memWe    <= 1'b0;
                        mem.memWStrb <= '0;
                        mem.memWData <= '0;
                        respValid    <= 1'b1;
                        if (!write_q) begin
                            readData <= align_load;
                        end
                    end
                end
                default: begin
                    state     <= LSU_IDLE;
                    respValid <= 1'b0;
                    fault     <= 1'b0;
                end
            endcase
        end
    end

endmodule
